popcount_sequencer: RTL and testbench

- Controller directly upstream of bit_counter. Accepts data words over a valid/ready interface and drives bit_counter's start/in handshake, one word at a time.
- Captures each result, emits it as a one-cycle output pulse, and keeps a saturating running total for the display stage.
- Includes a watchdog that flags and recovers from a counter that never raises done.

---
 rtl/popcount_pkg.sv | 22 ++
 rtl/watchdog_timer.sv | 28 ++
 rtl/popcount_sequencer.sv | 109 ++++++++++
 tb/tb_popcount_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types, default sizing and the saturating adder for the popcount sequencer.
package popcount_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int RES_W_DEF   = 4;
  localparam int TOTAL_W_DEF = 12;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  // Sum of two values clamped to the largest w-bit number (w <= 31).
  function automatic logic [31:0] sat_add(input logic [31:0] total,
                                          input logic [31:0] inc,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, total} + {1'b0, inc};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Cycle counter that flags a stall once en has been held TIMEOUT cycles since the last clr.
module watchdog_timer
  import popcount_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; parks at TIMEOUT-1 so timeout stays asserted until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 cnt <= '0;
    else if (clr)                               cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT - 1))     cnt <= cnt + CW'(1);
  end

  // Fires during the TIMEOUT-th enabled cycle, so the owner reacts on that edge.
  assign timeout = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/popcount_sequencer.sv
// Feeds words one at a time to bit_counter, reports each result as a pulse and
// keeps a saturating running total. A watchdog aborts words whose done never toggles.
// RES_W must be wide enough that 2^RES_W > DATA_W.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TOTAL_W = TOTAL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               clear,
  output logic               cnt_start,
  output logic [DATA_W-1:0]  cnt_data,
  input  logic               cnt_done,
  input  logic [RES_W-1:0]   cnt_result,
  output logic               out_valid,
  output logic [RES_W-1:0]   out_count,
  output logic [TOTAL_W-1:0] total,
  output logic               error
);

  seq_state_t state;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_to;

  assign in_ready = (state == IDLE);
  assign wd_en    = (state != IDLE);

  // Restart the watchdog on every edge that moves the FSM to a new state.
  always_comb begin
    wd_clr = 1'b0;
    case (state)
      IDLE:    wd_clr = in_valid;
      RUN:     wd_clr = cnt_done || wd_to;
      DRAIN:   wd_clr = !cnt_done || wd_to;
      default: wd_clr = 1'b1;
    endcase
  end

  watchdog_timer #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (wd_to)
  );

  // Handshake FSM with registered outputs; a real done beats a same-cycle timeout,
  // and clear overrides any total/error update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt_start <= 1'b0;
      cnt_data  <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      total     <= '0;
      error     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt_data  <= in_data;
            cnt_start <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (cnt_done) begin
            out_count <= cnt_result;
            out_valid <= 1'b1;
            total     <= TOTAL_W'(sat_add(32'(total), 32'(cnt_result), TOTAL_W));
            cnt_start <= 1'b0;
            state     <= DRAIN;
          end else if (wd_to) begin
            error     <= 1'b1;
            cnt_start <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!cnt_done) begin
            state <= IDLE;
          end else if (wd_to) begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          cnt_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
      if (clear) begin
        total <= '0;
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed bench: two sequencers (12-bit and 4-bit totals) share stimulus and a
// behavioural bit_counter driven from the main instance.
module tb_popcount_sequencer;

  localparam int DW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          clear = 1'b0;
  logic          cnt_done;
  logic [RW-1:0] cnt_result;

  logic          in_ready, cnt_start, out_valid, error;
  logic [DW-1:0] cnt_data;
  logic [RW-1:0] out_count;
  logic [11:0]   total;

  logic          s_in_ready, s_cnt_start, s_out_valid, s_error;
  logic [DW-1:0] s_cnt_data;
  logic [RW-1:0] s_out_count;
  logic [3:0]    s_total;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int viol   = 0;
  logic prev_start = 1'b0;

  logic m_hang  = 1'b0;
  logic m_force = 1'b0;
  int   m_cyc;

  always #5 clk = ~clk;

  popcount_sequencer #(.DATA_W(DW), .RES_W(RW), .TOTAL_W(12), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clear(clear), .cnt_start(cnt_start), .cnt_data(cnt_data), .cnt_done(cnt_done),
    .cnt_result(cnt_result), .out_valid(out_valid), .out_count(out_count),
    .total(total), .error(error)
  );

  popcount_sequencer #(.DATA_W(DW), .RES_W(RW), .TOTAL_W(4), .TIMEOUT(64)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .clear(clear), .cnt_start(s_cnt_start), .cnt_data(s_cnt_data), .cnt_done(cnt_done),
    .cnt_result(cnt_result), .out_valid(s_out_valid), .out_count(s_out_count),
    .total(s_total), .error(s_error)
  );

  // bit_counter model: done two cycles into a start, held until start drops.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_done <= 1'b0; cnt_result <= '0; m_cyc <= 0;
    end else if (m_force) begin
      cnt_done <= 1'b1; cnt_result <= RW'($countones(cnt_data));
    end else if (!cnt_start) begin
      cnt_done <= 1'b0; m_cyc <= 0;
    end else if (!m_hang && !cnt_done) begin
      if (m_cyc == 1) begin
        cnt_done <= 1'b1; cnt_result <= RW'($countones(cnt_data));
      end else m_cyc <= m_cyc + 1;
    end
  end

  // Pulse counter and start-while-done monitor.
  always @(negedge clk) begin
    if (out_valid) pulses <= pulses + 1;
    if (cnt_start && !prev_start && cnt_done) viol <= viol + 1;
    prev_start <= cnt_start;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int maxc, input string tag);
    int n = 0;
    while (!in_ready && n < maxc) begin tick; n++; end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_data = d; in_valid = 1'b1;
    wait_ready(300, "accept");
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int maxc, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick;
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic do_clear;
    clear = 1'b1; tick; clear = 1'b0;
  endtask

  initial begin
    int p0;
    // reset state
    repeat (3) tick;
    reset = 1'b1;
    tick;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cnt_start", 32'(cnt_start), 0);
    chk("rst_cnt_data", 32'(cnt_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_error", 32'(error), 0);

    // single word 0x14 -> 2
    p0 = pulses;
    send(8'h14);
    chk("w1_start", 32'(cnt_start), 1);
    chk("w1_data", 32'(cnt_data), 32'h14);
    chk("w1_busy", 32'(in_ready), 0);
    wait_ov(20, "w1_ov");
    chk("w1_count", 32'(out_count), 2);
    chk("w1_total", 32'(total), 2);
    chk("w1_startlow", 32'(cnt_start), 0);
    tick;
    chk("w1_pulse1", 32'(out_valid), 0);
    wait_ready(20, "w1_ready");
    tick;
    chk("w1_npulse", 32'(pulses - p0), 1);

    // back-to-back 20..24 -> 2,3,3,4,2
    do_clear;
    chk("clr_total", 32'(total), 0);
    p0 = pulses;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = DW'(20 + k);
      wait_ready(50, "b2b_ready");
      tick;
      chk("b2b_data", 32'(cnt_data), 32'(20 + k));
    end
    in_valid = 1'b0;
    wait_ready(50, "b2b_end");
    tick; tick;
    chk("b2b_pulses", 32'(pulses - p0), 5);
    chk("b2b_total", 32'(total), 14);
    chk("b2b_overlap", 32'(viol), 0);

    // saturation on the 4-bit instance
    do_clear;
    send(8'hFF); wait_ov(20, "sat1_ov");
    chk("sat1", 32'(s_total), 8);
    chk("sat1_main", 32'(total), 8);
    send(8'hFF); wait_ov(20, "sat2_ov");
    chk("sat2", 32'(s_total), 15);
    chk("sat2_main", 32'(total), 16);
    send(8'h01); wait_ov(20, "sat3_ov");
    chk("sat3", 32'(s_total), 15);
    chk("sat3_main", 32'(total), 17);
    chk("sat3_count", 32'(s_out_count), 1);

    // watchdog timeout in RUN
    do_clear;
    m_hang = 1'b1;
    p0 = pulses;
    send(8'h33);
    repeat (63) tick;
    chk("to_err_pre", 32'(error), 0);
    chk("to_start_pre", 32'(cnt_start), 1);
    tick;
    chk("to_err", 32'(error), 1);
    chk("to_start", 32'(cnt_start), 0);
    tick;
    chk("to_idle", 32'(in_ready), 1);
    m_hang = 1'b0;
    tick; tick;
    chk("to_nopulse", 32'(pulses - p0), 0);
    chk("to_total", 32'(total), 0);
    send(8'h0F); wait_ov(20, "to_next_ov");
    chk("to_next_count", 32'(out_count), 4);
    chk("to_sticky", 32'(error), 1);

    // stale done in IDLE
    wait_ready(20, "st_ready0");
    do_clear;
    chk("st_err_clr", 32'(error), 0);
    m_force = 1'b1;
    tick; tick;
    chk("st_done_hi", 32'(cnt_done), 1);
    chk("st_idle", 32'(in_ready), 1);
    chk("st_noov", 32'(out_valid), 0);
    send(8'h0F); wait_ov(5, "st_ov");
    chk("st_count", 32'(out_count), 4);
    wait_ready(100, "st_nodeadlock");
    chk("st_err", 32'(error), 1);
    m_force = 1'b0;
    tick; tick;

    // clear coinciding with a result
    do_clear;
    send(8'h1F); wait_ov(20, "cc_pre_ov");
    chk("cc_pre_total", 32'(total), 5);
    wait_ready(20, "cc_ready");
    send(8'h07);
    for (int i = 0; i < 20 && !cnt_done; i++) tick;
    chk("cc_done_seen", 32'(cnt_done), 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("cc_ov", 32'(out_valid), 1);
    chk("cc_count", 32'(out_count), 3);
    chk("cc_total", 32'(total), 0);
    chk("cc_err", 32'(error), 0);

    // reset mid-RUN
    wait_ready(20, "rm_ready0");
    send(8'h01); wait_ov(20, "rm_pre_ov");
    chk("rm_pre_total", 32'(total), 1);
    wait_ready(20, "rm_ready1");
    m_hang = 1'b1;
    send(8'h03);
    tick; tick;
    chk("rm_start_pre", 32'(cnt_start), 1);
    #2 reset = 1'b0;
    #1;
    chk("rm_start", 32'(cnt_start), 0);
    chk("rm_count", 32'(out_count), 0);
    chk("rm_total", 32'(total), 0);
    chk("rm_error", 32'(error), 0);
    chk("rm_data", 32'(cnt_data), 0);
    tick;
    m_hang = 1'b0;
    reset = 1'b1;
    tick;
    chk("rm_in_ready", 32'(in_ready), 1);
    chk("rm_start_post", 32'(cnt_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
